// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the hazard/forwarding scoreboard.
//            Defines the in-flight slot record, the register-file select
//            value and the legal parameter ranges.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Slot destination field is sized for the widest supported register
    // address; narrower REG_AW values are zero-extended on entry.
    localparam int SB_DEST_W = 8;

    // Forwarding select value meaning "use the register file read".
    localparam int SEL_RF = 0;

    // Legal parameter ranges (LOAD_LAT upper bound is DEPTH-1).
    localparam int DEPTH_MIN    = 2;
    localparam int DEPTH_MAX    = 7;
    localparam int LOAD_LAT_MIN = 1;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_r_en;
        logic [SB_DEST_W-1:0] dest;
    } sb_slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_scoreboard_slot_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sb_slot_pipe
// Purpose  : DEPTH-entry shift register recording every instruction in flight
//            after ID. Entry 0 is EXE, entry DEPTH-1 is WB. On advance the
//            new ID record (possibly a bubble) enters entry 0 and the oldest
//            entry retires. Reset clears all entries regardless of advance.
// Ports    : clk       - rising-edge clock
//            rst       - synchronous active-high reset
//            i_advance - shift enable (pipeline not frozen)
//            i_slot    - record entering EXE
//            o_slots   - all tracked entries, [0] = youngest
// Revision : 1.0 - initial release
// ============================================================================
module sb_slot_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_advance,
    input  sb_slot_t               i_slot,
    output sb_slot_t [DEPTH-1:0]   o_slots
);

    sb_slot_t [DEPTH-1:0] r_slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slots <= '0;
        end else if (i_advance) begin
            r_slots <= {r_slots[DEPTH-2:0], i_slot};
        end
    end

    assign o_slots = r_slots;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_scoreboard
// Purpose  : Stateful hazard detection and forwarding-select generation for
//            the 5-stage core. Tracks DEPTH in-flight instructions, raises a
//            combinational ID stall and registers forwarding selects for the
//            instruction entering EXE. A select value k means "take the
//            result of the instruction k stages ahead of EXE" (1 = MEM, ...),
//            0 means register file.
// Config   : HAZARD_STATS_EN - adds 32-bit wrapping stall_cnt / flush_cnt.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            FW_EN           - forwarding enable
//            issue_*         - ID instruction valid / wb / load / dest
//            src1, src2      - ID sources; two_src marks src2 live
//            freeze, flush   - pipeline hold / squash of ID instruction
//            hazard          - combinational stall request to IF/ID
//            sel1, sel2      - registered forwarding selects for EXE
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              FW_EN,
    input  logic              issue_valid,
    input  logic              issue_wb_en,
    input  logic              issue_mem_r_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic              freeze,
    input  logic              flush,
    output logic              hazard,
    output logic [SELW-1:0]   sel1,
    output logic [SELW-1:0]   sel2
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || LOAD_LAT < LOAD_LAT_MIN ||
        LOAD_LAT > DEPTH-1 || REG_AW > SB_DEST_W) begin : g_bad_params
        $error("hazard_forward_scoreboard: illegal parameter combination");
    end

    sb_slot_t [DEPTH-1:0] w_slots;
    sb_slot_t             w_in_slot;
    logic [DEPTH-2:0]     w_m1;
    logic [DEPTH-2:0]     w_m2;
    logic                 w_hazard;
    logic                 w_bubble;
    logic [SELW-1:0]      w_sel1_nxt;
    logic [SELW-1:0]      w_sel2_nxt;
    logic [SELW-1:0]      r_sel1;
    logic [SELW-1:0]      r_sel2;
    logic                 w_unused_slots;

    // Only slots ahead of WB matter at ID: the WB slot writes the register
    // file through, so it neither stalls nor needs a select.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < DEPTH-1; k++) begin
            w_m1[k] = issue_valid & w_slots[k].valid & w_slots[k].wb_en &
                      (w_slots[k].dest == SB_DEST_W'(src1));
            w_m2[k] = issue_valid & two_src & w_slots[k].valid & w_slots[k].wb_en &
                      (w_slots[k].dest == SB_DEST_W'(src2));
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < DEPTH-1; k++) begin
            if (!FW_EN) begin
                w_hazard = w_hazard | w_m1[k] | w_m2[k];
            end else if (k < LOAD_LAT) begin
                // Only a load still inside its latency window is unforwardable.
                w_hazard = w_hazard | (w_slots[k].mem_r_en & (w_m1[k] | w_m2[k]));
            end
        end
        if (flush) begin
            w_hazard = 1'b0;
        end
    end

    assign w_bubble = w_hazard | flush | ~issue_valid;

    always_comb begin
        w_in_slot          = '0;
        w_in_slot.valid    = ~w_bubble;
        w_in_slot.wb_en    = issue_wb_en & ~w_bubble;
        w_in_slot.mem_r_en = issue_mem_r_en & ~w_bubble;
        w_in_slot.dest     = SB_DEST_W'(issue_dest);
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        w_sel1_nxt = SELW'(SEL_RF);
        w_sel2_nxt = SELW'(SEL_RF);
        for (int k = DEPTH-2; k >= 0; k--) begin
            if (w_m1[k]) begin
                w_sel1_nxt = SELW'(k+1);
            end
            if (w_m2[k]) begin
                w_sel2_nxt = SELW'(k+1);
            end
        end
        if (!FW_EN || w_bubble) begin
            w_sel1_nxt = SELW'(SEL_RF);
            w_sel2_nxt = SELW'(SEL_RF);
        end
    end

    sb_slot_pipe #(
        .DEPTH     (DEPTH)
    ) u_slot_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_advance (~freeze),
        .i_slot    (w_in_slot),
        .o_slots   (w_slots)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel1 <= SELW'(SEL_RF);
            r_sel2 <= SELW'(SEL_RF);
        end else if (!freeze) begin
            r_sel1 <= w_sel1_nxt;
            r_sel2 <= w_sel2_nxt;
        end
    end

    assign hazard = w_hazard;
    assign sel1   = r_sel1;
    assign sel2   = r_sel2;

    // WB slot and load flags beyond LOAD_LAT are tracked but not read here.
    assign w_unused_slots = ^w_slots;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (!freeze) begin
            if (w_hazard) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
